// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-side arbiter: state encoding,
// tag field placement and the truncation counter geometry.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_e;

    localparam int TRUNC_W = 16;
    localparam logic [TRUNC_W-1:0] TRUNC_MAX = 16'hFFFF;

    // Beat counter wide enough for the largest permitted burst cap (255).
    localparam int BEAT_W = 8;

    // Position of the last flag inside a packed FIFO word.
    function automatic int last_bit(input int data_w);
        return data_w;
    endfunction

    // Lowest bit of the channel tag inside a packed FIFO word.
    function automatic int ch_lsb(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr.sv
// Combinational round-robin picker: rotate the request vector so the channel
// after last_grant sits at bit 0, priority-encode, then rotate the index back.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0]  start_s;
    logic [2*N-1:0] dbl_s;
    logic [N-1:0]   rot_s;
    logic [IW-1:0]  off_s;
    logic [IW:0]    sum_s;

    // Rotate, find the lowest requesting slot, map it back to a channel index.
    always_comb begin
        if (last_grant == IW'(N - 1)) begin
            start_s = '0;
        end else begin
            start_s = last_grant + IW'(1);
        end
        dbl_s = {req, req} >> start_s;
        rot_s = dbl_s[N-1:0];
        off_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_s[i]) begin
                off_s = IW'(i);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, start_s} + {1'b0, off_s};
        if (sum_s >= (IW + 1)'(N)) begin
            gnt_idx = IW'(sum_s - (IW + 1)'(N));
        end else begin
            gnt_idx = sum_s[IW-1:0];
        end
        gnt_any = |req;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one async FIFO write port between NUM_CH requesters, one burst per
// grant, tagging every word with {channel, last} for read-side demultiplexing.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 29,
    parameter int BURST_MAX = 16,
    localparam int CH_W     = $clog2(NUM_CH),
    localparam int FIFO_W   = CH_W + 1 + DATA_W
) (
    input  logic                     wr_clk,
    input  logic                     wr_rst_n,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH-1:0]        req_last,
    input  logic [NUM_CH*DATA_W-1:0] req_data,
    output logic [NUM_CH-1:0]        req_ready,
    output logic [FIFO_W-1:0]        fifo_din,
    output logic                     fifo_wr_en,
    input  logic                     fifo_full,
    output logic [CH_W-1:0]          grant_ch,
    output logic                     busy,
    output logic [TRUNC_W-1:0]       trunc_cnt
);

    localparam int LAST_BIT = last_bit(DATA_W);
    localparam int CH_LSB   = ch_lsb(DATA_W);
    localparam logic [BEAT_W-1:0] BEAT_CAP = BEAT_W'(BURST_MAX - 1);

    arb_state_e          state_q, state_d;
    logic [CH_W-1:0]     grant_ch_q, grant_ch_d;
    logic [CH_W-1:0]     last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [TRUNC_W-1:0]  trunc_cnt_q, trunc_cnt_d;
    logic                busy_q, busy_d;
    logic [FIFO_W-1:0]   din_q, din_d;

    logic                sel_valid_s;
    logic                sel_last_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                cap_s;
    logic                last_o_s;
    logic                acc_s;
    logic [FIFO_W-1:0]   packed_s;
    logic [CH_W-1:0]     rr_idx_s;
    logic                rr_any_s;

    rr_arbiter #(
        .N (NUM_CH)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt_idx    (rr_idx_s),
        .gnt_any    (rr_any_s)
    );

    // Select the granted channel and form the accept strobe; full gates it directly.
    always_comb begin
        sel_valid_s = req_valid[grant_ch_q];
        sel_last_s  = req_last[grant_ch_q];
        sel_data_s  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_ch_q == CH_W'(c)) begin
                sel_data_s = req_data[c*DATA_W +: DATA_W];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        cap_s    = (beat_cnt_q == BEAT_CAP);
        last_o_s = sel_last_s | cap_s;
        acc_s    = (state_q == ST_XFER) & sel_valid_s & ~fifo_full;
    end

    // Pack {channel, last, payload} for the FIFO word.
    always_comb begin
        packed_s                    = '0;
        packed_s[DATA_W-1:0]        = sel_data_s;
        packed_s[LAST_BIT]          = last_o_s;
        packed_s[CH_LSB +: CH_W]    = grant_ch_q;
    end

    // Drive the write port; outside a burst the data bus parks on the last word.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = acc_s;
        if (acc_s) begin
            req_ready[grant_ch_q] = 1'b1;
        end else begin
            req_ready = '0;
        end
        if (state_q == ST_XFER) begin
            fifo_din = packed_s;
        end else begin
            fifo_din = din_q;
        end
        grant_ch  = grant_ch_q;
        busy      = busy_q;
        trunc_cnt = trunc_cnt_q;
    end

    // Next-state logic for the grant/burst FSM and its bookkeeping registers.
    always_comb begin
        state_d      = state_q;
        grant_ch_d   = grant_ch_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        busy_d       = busy_q;
        din_d        = din_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && rr_any_s) begin
                    state_d    = ST_XFER;
                    grant_ch_d = rr_idx_s;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_XFER: begin
                din_d = packed_s;
                if (acc_s && last_o_s) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    last_grant_d = grant_ch_q;
                    beat_cnt_d   = '0;
                    // Only a cap-forced end counts; a genuine req_last on the cap beat does not.
                    if (cap_s && !sel_last_s && (trunc_cnt_q != TRUNC_MAX)) begin
                        trunc_cnt_d = trunc_cnt_q + TRUNC_W'(1);
                    end else begin
                        trunc_cnt_d = trunc_cnt_q;
                    end
                end else if (acc_s) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end else begin
                    beat_cnt_d = beat_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; last_grant resets to the top channel so channel 0 wins first.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state_q      <= ST_IDLE;
            grant_ch_q   <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            beat_cnt_q   <= '0;
            trunc_cnt_q  <= '0;
            busy_q       <= 1'b0;
            din_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_ch_q   <= grant_ch_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
            busy_q       <= busy_d;
            din_q        <= din_d;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Write-side arbiter that shares one `async_fifo` write port between `NUM_CH` requesters in the `wr_clk` domain. It grants one requester at a time for a burst, and packs each word with a channel tag and a last flag so the read-clock domain can demultiplex. Bursts end on `req_last` or on the `BURST_MAX` cap. The FIFO `full` flag is honoured combinationally, so no word is ever presented on a full cycle.

## Interface
Parameters:
- `NUM_CH`, 4: number of requesters (2..8).
- `DATA_W`, 29: payload width per requester.
- `BURST_MAX`, 16: maximum words per grant (1..255).
- `CH_W`, $clog2(NUM_CH): derived local parameter, not overridable.
- `FIFO_W`, CH_W+1+DATA_W: derived. Default 32, matching the FIFO `WIDTH`.

Ports:
- `wr_clk`, in, 1: clock (FIFO write domain).
- `wr_rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: permits new grants. Does not abort a burst in progress.
- `req_valid`, in, NUM_CH: per-channel word valid.
- `req_last`, in, NUM_CH: per-channel end-of-burst marker, qualified by valid.
- `req_data`, in, NUM_CH*DATA_W: channel c occupies bits [c*DATA_W +: DATA_W].
- `req_ready`, out, NUM_CH: one-hot or zero. The word is accepted when valid&&ready.
- `fifo_din`, out, FIFO_W: packed as {ch_id, last, data}.
- `fifo_wr_en`, out, 1: FIFO write strobe.
- `fifo_full`, in, 1: FIFO full flag.
- `grant_ch`, out, CH_W: currently or last granted channel.
- `busy`, out, 1: high while in XFER.
- `trunc_cnt`, out, 16: saturating count of bursts ended by the `BURST_MAX` cap.

## Operation
- FSM states:
  - IDLE: entered on reset.
    - If `enable` and any `req_valid`, choose the channel with round-robin priority starting at (`last_grant`+1) mod NUM_CH.
    - Register that channel into `grant_ch` and go to XFER.
  - XFER:
    - Accept condition: `acc` = `req_valid[grant_ch]` && !`fifo_full`.
    - `fifo_wr_en` = `acc`; `req_ready[grant_ch]` = `acc`.
    - `beat_cnt` increments on each `acc`.
    - `fifo_din` = {grant_ch, last_o, req_data[grant_ch]}, where `last_o` = `req_last[grant_ch]` || (`beat_cnt`==BURST_MAX-1).
    - On `acc` && `last_o`, go to IDLE. `last_grant` <= `grant_ch`. `beat_cnt` clears.
- Truncation: if `last_o` is forced by the cap while `req_last` is low, increment `trunc_cnt`, saturating at 0xFFFF. The channel's remaining words go out in a later grant.
- `req_valid` dropping mid-burst: the arbiter stays in XFER and waits. There is no timeout.
- `enable` low mid-burst: the current burst completes, then the FSM stays in IDLE.
- Outputs outside XFER: `fifo_wr_en` = 0 and `req_ready` = 0.
- `fifo_din` outside XFER: holds the last packed value; it is don't-care to consumers.

## Timing
- Reset values:
  - FSM = IDLE.
  - `grant_ch` = 0.
  - `last_grant` = NUM_CH-1, so channel 0 wins first.
  - `beat_cnt` = 0, `trunc_cnt` = 0, `busy` = 0.
  - `req_ready` = 0, `fifo_wr_en` = 0.
- Grant latency:
  - Request seen in IDLE at cycle N puts the FSM in XFER at cycle N+1.
  - The first write can occur at cycle N+1.
- One mandatory IDLE bubble cycle separates consecutive bursts.
- `fifo_wr_en` and `req_ready` are combinational from `fifo_full` and `req_valid` (same cycle). There is no registered path between `fifo_full` and the write strobe.
- Full-throughput burst: one word per cycle while valid and not full.
- Reset asserted mid-burst: all state clears asynchronously. The partial burst in the FIFO has no last flag, and the read side resynchronises on its own reset.

## Structure
- Shared package `fifo_arb_pkg`:
  - State encoding (IDLE, XFER).
  - Tag field offsets: LAST_BIT = DATA_W, CH_LSB = DATA_W+1.
  - Trunc counter width constant.
- Sub-module `rr_arbiter`: combinational.
  - Inputs: `req` vector and `last_grant`.
  - Outputs: `gnt_idx` and `gnt_any`.
  - Implemented with a rotate-and-priority-encode.

## Test plan
- Single channel: ch2 sends 3 words with `req_last` on the 3rd → 3 writes with `fifo_din[31:30]`=2 and last bit set on word 3 only. The FSM returns to IDLE, then `grant_ch` stays 2.
- Round-robin: all 4 channels valid, each sending 1-word bursts → grant order 0,1,2,3,0, with one bubble cycle between writes.
- Cap: ch1 streams 20 words with no last → first burst is 16 words with last forced on word 16, `trunc_cnt`=1. Ch1 is regranted for the remaining 4 only if no other channel is valid.
- Backpressure: hold `fifo_full` high for 5 cycles mid-burst → `fifo_wr_en`=0 and `req_ready`=0 in those cycles. No word is lost or duplicated, and data order is preserved.
- Enable and reset: drop `enable` at word 2 of a 4-word burst → the burst completes and no further grant is issued. Separately, assert `wr_rst_n` low mid-burst → all outputs are 0 immediately, and the next grant goes to ch0.
